// File: rtl/quad_beat_gather.sv
// Gathers four consecutive 16*WIDTH beats (low slice first) into one 64*WIDTH line.
// Short lines close early on in_last and are zero-filled above the last beat.
module quad_beat_gather #(
  parameter int unsigned WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [16*WIDTH-1:0]   in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [64*WIDTH-1:0]   out_data,
  output logic [2:0]            out_beats,
  input  logic                  out_ready
);

  localparam int unsigned BW = 16 * WIDTH;

  logic [1:0]      cnt_q, cnt_d;
  logic [3*BW-1:0] acc_q, acc_d;
  logic [4*BW-1:0] out_data_q, out_data_d;
  logic [2:0]      out_beats_q, out_beats_d;
  logic            out_valid_q, out_valid_d;

  logic            in_fire;
  logic            out_fire;
  logic            closing;
  logic [4*BW-1:0] line;

  always_comb begin
    in_ready = ~flush & ~(out_valid_q & ~out_ready);
    in_fire  = in_valid & in_ready;
    out_fire = out_valid_q & out_ready;
    closing  = in_fire & ((cnt_q == 2'd3) | in_last);

    // New beat lands at slice cnt; lower slices come from acc, upper stay zero.
    line = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (k == 32'(cnt_q)) line[k*BW +: BW] = in_data;
    end
    for (int unsigned k = 0; k < 3; k++) begin
      if (k < 32'(cnt_q)) line[k*BW +: BW] = acc_q[k*BW +: BW];
    end

    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_beats_d = out_beats_q;
    out_valid_d = out_valid_q;

    if (flush) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (closing) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (in_fire) begin
      cnt_d = cnt_q + 2'd1;
      for (int unsigned k = 0; k < 3; k++) begin
        if (k == 32'(cnt_q)) acc_d[k*BW +: BW] = in_data;
      end
    end

    if (closing) begin
      out_data_d  = line;
      out_beats_d = {1'b0, cnt_q} + 3'd1;
      out_valid_d = 1'b1;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_beats_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_beats = out_beats_q;

endmodule

// File: tb/tb_quad_beat_gather.sv
// Randomized and directed checks of quad_beat_gather (WIDTH=1) against a queue-based
// line model: beats collect in a queue and a line is their concatenation, low beat first.
module tb_quad_beat_gather;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [63:0] out_data;
  logic [2:0]  out_beats;
  logic        out_ready = 1'b1;

  quad_beat_gather #(.WIDTH(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_beats (out_beats),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [15:0] pq[$];
  logic        m_valid = 1'b0;
  logic [63:0] m_data  = '0;
  logic [2:0]  m_beats = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pq.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_beats = '0;
  endtask

  // One clock cycle: drive, check visible outputs against the model, advance the model.
  task automatic step(input logic v, input logic [15:0] d, input logic last,
                      input logic fl, input logic ordy);
    logic exp_ready;
    logic fire;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_last   = last;
    flush     = fl;
    out_ready = ordy;
    #1;
    exp_ready = !fl && !(m_valid && !ordy);
    check("in_ready",  {63'd0, in_ready},  {63'd0, exp_ready});
    check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    check("out_data",  out_data,           m_data);
    check("out_beats", {61'd0, out_beats}, {61'd0, m_beats});
    fire = v && exp_ready;
    if (fire) pq.push_back(d);
    if (fire && (last || pq.size() == 4)) begin
      m_data = '0;
      foreach (pq[i]) m_data = m_data | (64'(pq[i]) << (16 * i));
      m_beats = 3'(pq.size());
      m_valid = 1'b1;
      pq.delete();
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    if (fl) pq.delete();
    @(posedge clk);
  endtask

  task automatic expect_line(input string tag, input logic [63:0] d, input logic [2:0] b);
    #1;
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({tag, "_data"},  out_data,           d);
    check({tag, "_beats"}, {61'd0, out_beats}, {61'd0, b});
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_data"},  out_data,           64'd0);
    check({tag, "_beats"}, {61'd0, out_beats}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_data",  out_data,           64'd0);
    check("rst_beats", {61'd0, out_beats}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    step(1'b1, 16'h1111, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h2222, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h3333, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h4444, 1'b0, 1'b0, 1'b1);
    expect_line("full", 64'h4444_3333_2222_1111, 3'd4);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 16'(i), 1'b0, 1'b0, 1'b1);
      if (i == 4) expect_line("stream0", 64'h0004_0003_0002_0001, 3'd4);
      if (i == 8) expect_line("stream1", 64'h0008_0007_0006_0005, 3'd4);
    end

    step(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'hBBBB, 1'b1, 1'b0, 1'b1);
    expect_line("short", 64'h0000_0000_BBBB_AAAA, 3'd2);
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b1);
    expect_line("noresidue", 64'h0004_0003_0002_0001, 3'd4);

    step(1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    expect_line("one", 64'h0, 3'd1);
    step(1'b1, 16'hC0DE, 1'b1, 1'b0, 1'b1);
    expect_line("one_b", 64'h0000_0000_0000_C0DE, 3'd1);

    for (int i = 1; i <= 4; i++) step(1'b1, 16'h10 + 16'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0099, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0099, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0099, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h009A, 1'b1, 1'b0, 1'b1);
    expect_line("afterhold", 64'h0000_0000_009A_0099, 3'd2);

    step(1'b1, 16'h5555, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h6666, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'h7777, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b1);
    expect_line("flush", 64'h0004_0003_0002_0001, 3'd4);
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);

    for (int i = 1; i <= 4; i++) step(1'b1, 16'h20 + 16'(i), 1'b0, 1'b0, 1'b0);
    async_reset("rst_held");
    step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1);
    async_reset("rst_mid");
    for (int i = 1; i <= 4; i++) step(1'b1, 16'h30 + 16'(i), 1'b0, 1'b0, 1'b1);
    expect_line("postrst", 64'h0034_0033_0032_0031, 3'd4);

    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 16'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 3) != 0));
    end
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/quad_beat_gather.md
Name: quad_beat_gather

Overview:
- Downstream companion of the 64-to-16 shift serializer: collects four consecutive 16*WIDTH beats and rebuilds the 64*WIDTH line.
- Beat 0 is the least-significant slice, matching the serializer's low-slice-first emission order.
- Ready/valid handshake on both sides, single-line output buffer, full throughput (one beat per cycle sustained).
- Supports short lines via in_last with zero fill, and a synchronous flush of a partially gathered line.

Parameters:
WIDTH, 1, slice multiplier; beat width 16*WIDTH, line width 64*WIDTH.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_data holds a beat
in_data  input  16*WIDTH  beat payload
in_last  input  1  qualifies the beat as the final one of the line
in_ready  output  1  block accepts a beat this cycle
flush  input  1  discard the partially gathered line
out_valid  output  1  out_data/out_beats hold a complete line
out_data  output  64*WIDTH  assembled line, beat k at bits [16*WIDTH*(k+1)-1 : 16*WIDTH*k]
out_beats  output  3  number of real beats in the line, 1..4
out_ready  input  1  consumer takes the line this cycle

Behaviour:
- Beat handshake: in_fire = in_valid & in_ready. Line handshake: out_fire = out_valid & out_ready.
- State:
  - cnt[1:0]: next slice index.
  - acc: 48*WIDTH accumulator holding slices 0-2.
  - Output register: out_data, out_beats, out_valid.
- Reset (async, rst=1):
  - cnt=0, acc=0, out_valid=0, out_data=0, out_beats=0.
  - Outputs are held at these values for the whole time rst is high.
  - Reset mid-line discards the partial line and any held output.
- in_ready = ~flush & ~(out_valid & ~out_ready). This is combinational. A beat may be accepted in the same cycle the held line is taken.
- On in_fire, when not closing the line (cnt<3 and in_last=0): acc slice[cnt] <= in_data, cnt <= cnt+1.
- On in_fire, when closing the line (cnt==3 or in_last=1):
  - out_data <= {in_data at slice cnt, acc slices below cnt, zeros above cnt}.
  - out_beats <= cnt+1; out_valid <= 1; cnt <= 0.
  - acc is cleared to 0, so stale data never leaks into a later short line.
- Latency: out_valid asserts on the cycle after the closing beat's in_fire.
- If out_fire occurs with no closing beat in the same cycle: out_valid <= 0. out_data and out_beats hold their values; they are don't-care while out_valid=0, but the bench checks they are unchanged.
- out_fire and a closing in_fire in the same cycle: the new line replaces the old one and out_valid stays 1. This gives back-to-back lines with no bubble.
- Holding while blocked: out_valid=1, out_ready=0, cnt<3 and in_last=0 still accepts beats into acc. in_ready drops only when the next beat would overwrite the held line. To keep one expression, in_ready is the simpler conservative form given above and applies to every cnt. Implement exactly that form.
- flush=1:
  - in_ready=0; cnt <= 0; acc <= 0.
  - The held output line is not affected; out_valid/out_fire proceed normally.
  - Flush with cnt=0 is a no-op.
- in_last on beat 0 yields a 1-beat line, out_beats=1, upper 48*WIDTH bits zero.
- in_last is ignored when in_valid=0. Inputs with in_valid=0 never change state.
- cnt wraps 3->0 only via line close. There is no overflow path.
- Expected implementation: ~150-250 lines. Use an explicit slice-select loop for the WIDTH-generic placement.

Test Plan:
- WIDTH=1, out_ready=1, beats 16'h1111, 16'h2222, 16'h3333, 16'h4444 on 4 consecutive cycles -> one cycle after beat 3: out_valid=1, out_data=64'h4444_3333_2222_1111, out_beats=4. out_valid=0 the following cycle.
- Sustained stream of 8 beats 16'h0001..16'h0008, out_ready=1 -> lines 64'h0004_0003_0002_0001 then 64'h0008_0007_0006_0005 on consecutive out_fire windows. in_ready stays 1 throughout.
- Beats 16'hAAAA, 16'hBBBB with in_last on the second -> out_data=64'h0000_0000_BBBB_AAAA, out_beats=2. A following full line contains no AAAA/BBBB residue.
- Line held with out_ready=0 -> in_ready=0 and in_valid beats are not consumed. Raise out_ready -> line taken; the next beat is accepted in that same cycle.
- Two beats 16'h5555, 16'h6666, then flush, then 4 beats 16'h1..16'h4 -> only 64'h0004_0003_0002_0001 emitted, out_beats=4.
- Assert rst asynchronously mid-line (cnt=2) and while out_valid=1 -> out_valid=0, out_data=0 immediately without a clock edge. After release, a fresh 4-beat line assembles correctly from slice 0.
